// File: rtl/circle_scheduler_pkg.sv
// Shared types and widths for the circle command scheduler.
package circle_scheduler_pkg;

  localparam int COLOUR_W = 3;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int R_W      = 8;
  localparam int CMD_W    = COLOUR_W + X_W + Y_W + R_W;

  localparam logic [7:0] DRAWN_MAX = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  typedef struct packed {
    logic [COLOUR_W-1:0] colour;
    logic [X_W-1:0]      cx;
    logic [Y_W-1:0]      cy;
    logic [R_W-1:0]      radius;
  } circle_cmd_t;

endpackage

// File: rtl/circle_scheduler_if.sv
// Command port between a requester and the circle scheduler.
interface circle_scheduler_if;
  import circle_scheduler_pkg::*;

  // A command transfers on a rising edge where cmd_valid && cmd_ready; the
  // requester keeps payload stable while valid, ready never looks at valid.
  logic                cmd_valid;
  logic                cmd_ready;
  logic [COLOUR_W-1:0] cmd_colour;
  logic [X_W-1:0]      cmd_cx;
  logic [Y_W-1:0]      cmd_cy;
  logic [R_W-1:0]      cmd_radius;

  modport master (
    output cmd_valid, cmd_colour, cmd_cx, cmd_cy, cmd_radius,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_colour, cmd_cx, cmd_cy, cmd_radius,
    output cmd_ready
  );

endinterface

// File: rtl/circle_scheduler_cmd_fifo.sv
// Command FIFO with extra-MSB pointers; storage is deliberately not reset.
module cmd_fifo #(
  parameter int  DEPTH     = 4,
  parameter type payload_t = logic [25:0]
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  payload_t                 push_data,
  output payload_t                 head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  payload_t      mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/circle_scheduler.sv
// Queues circle commands and feeds them one at a time to a circle engine
// through a start/done four-phase handshake.
module circle_scheduler
  import circle_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  circle_scheduler_if.slave      cmd,
  output logic                   circ_start,
  input  logic                   circ_done,
  output logic [COLOUR_W-1:0]    circ_colour,
  output logic [X_W-1:0]         circ_cx,
  output logic [Y_W-1:0]         circ_cy,
  output logic [R_W-1:0]         circ_radius,
  output logic                   busy,
  output logic                   all_done,
  output logic [7:0]             drawn_count,
  output state_t                 state_dbg,
  output logic [$clog2(DEPTH):0] fifo_level
);

  state_t      state;
  state_t      state_nxt;
  circle_cmd_t push_cmd;
  circle_cmd_t head_cmd;
  logic        full;
  logic        empty;
  logic        pop;
  logic        start_nxt;
  logic        count_en;

  assign push_cmd.colour = cmd.cmd_colour;
  assign push_cmd.cx     = cmd.cmd_cx;
  assign push_cmd.cy     = cmd.cmd_cy;
  assign push_cmd.radius = cmd.cmd_radius;
  assign cmd.cmd_ready   = !full;

  cmd_fifo #(
    .DEPTH     (DEPTH),
    .payload_t (circle_cmd_t)
  ) u_cmd_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd.cmd_valid),
    .pop       (pop),
    .push_data (push_cmd),
    .head      (head_cmd),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_nxt = state;
    start_nxt = circ_start;
    pop       = 1'b0;
    count_en  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          start_nxt = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (circ_done) begin
          start_nxt = 1'b0;
          state_nxt = ST_ACK;
        end
      end
      ST_ACK: begin
        // Wait for the engine to drop done so one completion counts once.
        start_nxt = 1'b0;
        if (!circ_done) begin
          count_en  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        start_nxt = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      circ_start  <= 1'b0;
      circ_colour <= '0;
      circ_cx     <= '0;
      circ_cy     <= '0;
      circ_radius <= '0;
      drawn_count <= '0;
    end else begin
      state      <= state_nxt;
      circ_start <= start_nxt;
      if (pop) begin
        circ_colour <= head_cmd.colour;
        circ_cx     <= head_cmd.cx;
        circ_cy     <= head_cmd.cy;
        circ_radius <= head_cmd.radius;
      end
      if (count_en && (drawn_count != DRAWN_MAX)) drawn_count <= drawn_count + 8'd1;
    end
  end

  assign busy      = (state == ST_RUN) || (state == ST_ACK);
  assign all_done  = empty && (state == ST_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_circle_scheduler.sv
// Bench for circle_scheduler: queue-level model checked every cycle, plus
// directed scenarios with hand-computed expectations and a random phase.
module tb_circle_scheduler;
  import circle_scheduler_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int W     = CMD_W;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic                circ_start;
  logic                circ_done;
  logic [COLOUR_W-1:0] circ_colour;
  logic [X_W-1:0]      circ_cx;
  logic [Y_W-1:0]      circ_cy;
  logic [R_W-1:0]      circ_radius;
  logic                busy;
  logic                all_done;
  logic [7:0]          drawn_count;
  state_t              state_dbg;
  logic [LW-1:0]       fifo_level;

  circle_scheduler_if cmd_if();

  circle_scheduler #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd         (cmd_if),
    .circ_start  (circ_start),
    .circ_done   (circ_done),
    .circ_colour (circ_colour),
    .circ_cx     (circ_cx),
    .circ_cy     (circ_cy),
    .circ_radius (circ_radius),
    .busy        (busy),
    .all_done    (all_done),
    .drawn_count (drawn_count),
    .state_dbg   (state_dbg),
    .fifo_level  (fifo_level)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  logic [W-1:0] exp_q[$];   // commands the model holds in the queue
  logic [W-1:0] seen_q[$];  // operands the DUT presented on each start
  logic [W-1:0] m_cur   = '0;
  int           m_phase = 0;  // 0 idle, 1 engine started, 2 waiting done release
  int           m_drawn = 0;
  int           m_acc   = 0;
  bit           chk_en  = 1'b0;
  logic         prev_start = 1'b0;

  int done_delay    = 10;
  int done_hold     = 0;
  bit engine_stall  = 1'b0;
  bit engine_en     = 1'b1;
  bit spurious_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic state_t phase_state(input int ph);
    case (ph)
      0:       return ST_IDLE;
      1:       return ST_RUN;
      default: return ST_ACK;
    endcase
  endfunction

  function automatic logic [W-1:0] dut_ops();
    return {circ_colour, circ_cx, circ_cy, circ_radius};
  endfunction

  // ---------------- behavioural model ----------------
  task automatic model_step();
    bit acc;
    acc = cmd_if.cmd_valid && (exp_q.size() < DEPTH);
    case (m_phase)
      0: if (exp_q.size() > 0) begin
           m_cur   = exp_q.pop_front();
           m_phase = 1;
         end
      1: if (circ_done) m_phase = 2;
      default: if (!circ_done) begin
           m_phase = 0;
           if (m_drawn < 255) m_drawn++;
         end
    endcase
    if (acc) begin
      exp_q.push_back({cmd_if.cmd_colour, cmd_if.cmd_cx, cmd_if.cmd_cy, cmd_if.cmd_radius});
      m_acc++;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      exp_q.delete();
      m_cur   = '0;
      m_phase = 0;
      m_drawn = 0;
    end else begin
      model_step();
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("cmd_ready",   cmd_if.cmd_ready, exp_q.size() < DEPTH);
      check("circ_start",  circ_start, m_phase == 1);
      check("busy",        busy, m_phase != 0);
      check("all_done",    all_done, (exp_q.size() == 0) && (m_phase == 0));
      check("drawn_count", drawn_count, m_drawn);
      check("operands",    dut_ops(), m_cur);
      check("fifo_level",  fifo_level, exp_q.size());
      check("state",       state_dbg, phase_state(m_phase));
    end
    if (circ_start && !prev_start) seen_q.push_back(dut_ops());
    prev_start = circ_start;
  end

  // ---------------- engine model ----------------
  int eng_cnt  = 0;
  int hold_cnt = 0;
  initial begin
    circ_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        circ_done = 1'b0;
        eng_cnt   = 0;
        hold_cnt  = 0;
      end else if (!engine_en) begin
        circ_done = spurious_done;
      end else if (circ_start && !circ_done) begin
        if (!engine_stall) begin
          eng_cnt++;
          if (eng_cnt >= done_delay) circ_done = 1'b1;
        end
      end else if (!circ_start && circ_done) begin
        if (hold_cnt >= done_hold) begin
          circ_done = 1'b0;
          hold_cnt  = 0;
          eng_cnt   = 0;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_payload(input logic [W-1:0] c);
    {cmd_if.cmd_colour, cmd_if.cmd_cx, cmd_if.cmd_cy, cmd_if.cmd_radius} = c;
  endtask

  task automatic push_cmd(input logic [W-1:0] c);
    int start_acc;
    int guard;
    start_acc = m_acc;
    guard     = 0;
    set_payload(c);
    cmd_if.cmd_valid = 1'b1;
    do begin
      tick();
      guard++;
    end while ((m_acc == start_acc) && (guard < 200));
    cmd_if.cmd_valid = 1'b0;
    if (m_acc == start_acc) timeout_fail("push");
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n;
    n = 0;
    while (!all_done && (n < budget)) begin
      tick();
      n++;
    end
    if (!all_done) timeout_fail(name);
  endtask

  task automatic wait_state(input state_t st, input int budget, input string name);
    int n;
    n = 0;
    while ((state_dbg != st) && (n < budget)) begin
      tick();
      n++;
    end
    if (state_dbg != st) timeout_fail(name);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  logic [W-1:0] single_cmd;
  logic [W-1:0] vec [6];
  int           acc0;

  initial begin
    cmd_if.cmd_valid = 1'b0;
    set_payload('0);
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);

    check("rst cmd_ready",  cmd_if.cmd_ready, 1);
    check("rst busy",       busy, 0);
    check("rst all_done",   all_done, 1);
    check("rst drawn",      drawn_count, 0);
    check("rst circ_start", circ_start, 0);
    check("rst operands",   dut_ops(), 0);

    // Single command, engine done 10 cycles after start.
    done_delay = 10;
    done_hold  = 0;
    single_cmd = {3'b010, 8'd80, 7'd60, 8'd40};
    set_payload(single_cmd);
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("single start_not_yet", circ_start, 0);
    tick();
    check("single start", circ_start, 1);
    check("single ops", dut_ops(), {3'b010, 8'd80, 7'd60, 8'd40});
    wait_idle(100, "single drain");
    check("single drawn", drawn_count, 1);
    check("single all_done", all_done, 1);

    // Fill with the engine stalled: 1 popped + 4 queued, 6th push dropped.
    seen_q.delete();
    engine_stall = 1'b1;
    for (int i = 0; i < 6; i++) vec[i] = W'($urandom());
    for (int i = 0; i < 6; i++) begin
      set_payload(vec[i]);
      cmd_if.cmd_valid = 1'b1;
      tick();
      if (i == 4) check("fill ready_low", cmd_if.cmd_ready, 0);
    end
    cmd_if.cmd_valid = 1'b0;
    check("fill level", fifo_level, 4);
    check("fill ready", cmd_if.cmd_ready, 0);
    done_delay   = 2;
    engine_stall = 1'b0;
    wait_idle(300, "fill drain");
    check("fill drawn", drawn_count, 6);
    check("fill seen count", seen_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seen_q.size()) check("fill order", seen_q[i], vec[i]);

    // Done held 3 cycles after start drops; second start waits for release.
    seen_q.delete();
    done_delay = 3;
    done_hold  = 3;
    push_cmd(vec[0]);
    push_cmd(vec[1]);
    wait_state(ST_ACK, 50, "hs reach ack");
    for (int k = 0; k < 3; k++) begin
      check("hs in ack", state_dbg, ST_ACK);
      check("hs start low", circ_start, 0);
      tick();
    end
    wait_idle(100, "hs drain");
    check("hs drawn", drawn_count, 8);
    if (seen_q.size() == 2) begin
      check("hs order0", seen_q[0], vec[0]);
      check("hs order1", seen_q[1], vec[1]);
    end else timeout_fail("hs seen count");

    // Done pulses while idle are ignored.
    engine_en     = 1'b0;
    spurious_done = 1'b1;
    tick(4);
    check("spur state", state_dbg, ST_IDLE);
    check("spur drawn", drawn_count, 8);
    check("spur start", circ_start, 0);
    spurious_done = 1'b0;
    tick(2);
    engine_en = 1'b1;

    // Push on the same edge the FSM pops at occupancy 2.
    seen_q.delete();
    done_hold    = 0;
    done_delay   = 2;
    engine_stall = 1'b1;
    for (int i = 0; i < 4; i++) vec[i] = W'($urandom());
    push_cmd(vec[0]);
    push_cmd(vec[1]);
    push_cmd(vec[2]);
    check("simul pre level", fifo_level, 2);
    engine_stall = 1'b0;
    wait_state(ST_IDLE, 50, "simul reach idle");
    set_payload(vec[3]);
    cmd_if.cmd_valid = 1'b1;
    tick();
    cmd_if.cmd_valid = 1'b0;
    check("simul level", fifo_level, 2);
    check("simul start", circ_start, 1);
    wait_idle(200, "simul drain");
    check("simul drawn", drawn_count, 12);
    check("simul seen count", seen_q.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < seen_q.size()) check("simul order", seen_q[i], vec[i]);

    // Reset while running with three queued.
    do_reset();
    engine_stall = 1'b1;
    for (int i = 0; i < 4; i++) push_cmd(W'($urandom()));
    check("rrun level", fifo_level, 3);
    check("rrun busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("rrun start", circ_start, 0);
    check("rrun all_done", all_done, 1);
    check("rrun level0", fifo_level, 0);
    tick(2);
    rst_n        = 1'b1;
    engine_stall = 1'b0;
    tick(5);
    check("rrun drawn", drawn_count, 0);
    check("rrun idle", all_done, 1);

    // Random traffic with a randomly paced engine.
    seen_q.delete();
    acc0 = m_acc;
    for (int c = 0; c < 1500; c++) begin
      if ((c % 50) == 0) begin
        done_delay = $urandom_range(1, 4);
        done_hold  = $urandom_range(0, 2);
      end
      cmd_if.cmd_valid = ($urandom_range(0, 99) < 40);
      set_payload(W'($urandom()));
      tick();
    end
    cmd_if.cmd_valid = 1'b0;
    wait_idle(500, "random drain");
    check("random draws", seen_q.size(), m_acc - acc0);

    // Saturation after 260 draws.
    do_reset();
    done_delay = 1;
    done_hold  = 0;
    for (int i = 0; i < 260; i++) push_cmd(W'($urandom()));
    wait_idle(2000, "sat drain");
    check("sat drawn", drawn_count, 255);

    chk_en = 1'b0;
    tick(1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish at %0t", $time);
    $fatal(1, "global timeout");
  end

endmodule
